// File: rtl/sparc_exu_reg_wrctl_pkg.sv
// Shared definitions for the EXU per-thread write-port controller:
// thread count, thread-index type and one-hot/index conversion helpers.
package sparc_exu_reg_wrctl_pkg;

    localparam int EXU_NTHR = 4;

    typedef logic [1:0] thr_idx_t;

    // Encodes a one-hot vector; a zero or multi-hot input gives an arbitrary index.
    function automatic thr_idx_t onehot2idx(input logic [EXU_NTHR-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

    function automatic logic [EXU_NTHR-1:0] idx2onehot(input thr_idx_t idx);
        logic [EXU_NTHR-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sparc_exu_rr_arb4.sv
// Combinational 4-way round-robin arbiter; the search starts one past the
// most recently granted thread so every requester is served in turn.
module sparc_exu_rr_arb4
    import sparc_exu_reg_wrctl_pkg::*;
(
    input  logic [3:0] req,
    input  logic       en,
    input  logic [1:0] last,
    output logic [3:0] gnt,
    output logic       gnt_vld,
    output logic [1:0] gnt_idx
);

    thr_idx_t cand;
    thr_idx_t sel;
    logic     found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        // Offsets 1..4 wrap through 2 bits, so last itself is checked last.
        for (int k = 1; k <= EXU_NTHR; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign gnt_vld = en & found;
    assign gnt_idx = sel;
    assign gnt     = gnt_vld ? idx2onehot(sel) : 4'b0000;

endmodule

// File: rtl/sparc_exu_reg_wrctl.sv
// Per-thread write-port controller: last-write-wins pending buffers, one
// registered write per cycle, optional forwarding under SPARC_EXU_REG_WRCTL_FWD_EN.
module sparc_exu_reg_wrctl
    import sparc_exu_reg_wrctl_pkg::*;
#(
    parameter int SIZE = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [EXU_NTHR-1:0]      req_vld,
    input  logic [EXU_NTHR*SIZE-1:0] req_data,
    input  logic                     wr_hold,
    input  logic [EXU_NTHR-1:0]      fwd_thr,
    output logic                     wen_w,
    output logic [EXU_NTHR-1:0]      thr_w,
    output logic [SIZE-1:0]          data_in_w,
    output logic [EXU_NTHR-1:0]      pend,
    output logic                     fwd_vld,
    output logic [SIZE-1:0]          fwd_data
);

    logic [EXU_NTHR-1:0]           pend_q;
    logic [EXU_NTHR-1:0][SIZE-1:0] pbuf_q;
    logic [EXU_NTHR-1:0][SIZE-1:0] req_slice;
    logic                          wen_q;
    logic [EXU_NTHR-1:0]           thr_q;
    logic [SIZE-1:0]               data_q;
    thr_idx_t                      last_q;

    logic [EXU_NTHR-1:0] gnt;
    logic                gnt_vld;
    thr_idx_t            gnt_idx;

    assign req_slice = req_data;

    sparc_exu_rr_arb4 u_arb (
        .req     (pend_q),
        .en      (~wr_hold),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // A new request outranks the grant clear: the old value issues, the new one stays.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            pbuf_q <= '0;
        end else begin
            for (int t = 0; t < EXU_NTHR; t++) begin
                if (req_vld[t]) begin
                    pend_q[t] <= 1'b1;
                    pbuf_q[t] <= req_slice[t];
                end else if (gnt[t]) begin
                    pend_q[t] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wen_q  <= 1'b0;
            thr_q  <= '0;
            data_q <= '0;
            last_q <= thr_idx_t'(EXU_NTHR - 1);
        end else begin
            wen_q  <= gnt_vld;
            thr_q  <= gnt;
            data_q <= gnt_vld ? pbuf_q[gnt_idx] : '0;
            if (gnt_vld) begin
                last_q <= gnt_idx;
            end
        end
    end

    assign wen_w     = wen_q;
    assign thr_w     = thr_q;
    assign data_in_w = data_q;
    assign pend      = pend_q;

`ifdef SPARC_EXU_REG_WRCTL_FWD_EN
    logic     pend_hit;
    logic     iss_hit;
    thr_idx_t fwd_idx;

    // The pending copy is always newer than the one currently being written.
    always_comb begin
        fwd_idx  = onehot2idx(fwd_thr);
        pend_hit = |(pend_q & fwd_thr);
        iss_hit  = wen_q & (|(thr_q & fwd_thr));
        fwd_vld  = pend_hit | iss_hit;
        if (pend_hit) begin
            fwd_data = pbuf_q[fwd_idx];
        end else if (iss_hit) begin
            fwd_data = data_q;
        end else begin
            fwd_data = '0;
        end
    end
`else
    logic unused_fwd_thr;
    assign unused_fwd_thr = ^fwd_thr;
    assign fwd_vld        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_sparc_exu_reg_wrctl.sv
// Self-checking bench for sparc_exu_reg_wrctl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural thread model.
module tb_sparc_exu_reg_wrctl;

    localparam int SIZE = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_vld;
    logic [11:0] req_data;
    logic        wr_hold;
    logic [3:0]  fwd_thr;
    logic        wen_w;
    logic [3:0]  thr_w;
    logic [2:0]  data_in_w;
    logic [3:0]  pend;
    logic        fwd_vld;
    logic [2:0]  fwd_data;

    int checks = 0;
    int errors = 0;

    sparc_exu_reg_wrctl #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_vld   (req_vld),
        .req_data  (req_data),
        .wr_hold   (wr_hold),
        .fwd_thr   (fwd_thr),
        .wen_w     (wen_w),
        .thr_w     (thr_w),
        .data_in_w (data_in_w),
        .pend      (pend),
        .fwd_vld   (fwd_vld),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    // Reference model: per-thread pending flag/value, last granted thread, write stream.
    bit         m_pend [4];
    logic [2:0] m_pbuf [4];
    int         m_last;
    logic       m_wen;
    logic [3:0] m_thr;
    logic [2:0] m_data;
    bit         model_ok = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int g;
        if (reset) begin
            for (int t = 0; t < 4; t++) begin
                m_pend[t] = 0;
                m_pbuf[t] = '0;
            end
            m_last   = 3;
            m_wen    = 0;
            m_thr    = '0;
            m_data   = '0;
            model_ok = 1;
        end else if (model_ok) begin
            g = -1;
            if (!wr_hold) begin
                for (int k = 1; k <= 4; k++) begin
                    if (g < 0 && m_pend[(m_last + k) % 4]) g = (m_last + k) % 4;
                end
            end
            if (g >= 0) begin
                m_wen  = 1;
                m_thr  = 4'(1 << g);
                m_data = m_pbuf[g];
                m_pend[g] = 0;
                m_last = g;
            end else begin
                m_wen  = 0;
                m_thr  = '0;
                m_data = '0;
            end
            for (int t = 0; t < 4; t++) begin
                if (req_vld[t]) begin
                    m_pend[t] = 1;
                    m_pbuf[t] = req_data[t*3 +: 3];
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        logic [3:0] pv;
        logic       ev;
        logic [2:0] ed;
        int         f;
        assert ($onehot0(fwd_thr));
        if (model_ok) begin
            for (int t = 0; t < 4; t++) pv[t] = m_pend[t];
            ev = 0;
            ed = '0;
`ifdef SPARC_EXU_REG_WRCTL_FWD_EN
            f = -1;
            for (int t = 0; t < 4; t++) if (fwd_thr[t]) f = t;
            if (f >= 0) begin
                if (m_pend[f]) begin
                    ev = 1;
                    ed = m_pbuf[f];
                end else if (m_wen && m_thr[f]) begin
                    ev = 1;
                    ed = m_data;
                end
            end
`else
            f = 0;
`endif
            chk("wen_w", 16'(wen_w), 16'(m_wen));
            chk("thr_w", 16'(thr_w), 16'(m_thr));
            chk("data_in_w", 16'(data_in_w), 16'(m_data));
            chk("pend", 16'(pend), 16'(pv));
            chk("fwd_vld", 16'(fwd_vld), 16'(ev));
            chk("fwd_data", 16'(fwd_data), 16'(ed));
        end
    end

    // Applies one cycle of inputs, returns 1 time unit after the edge that consumed them.
    task automatic cyc(input logic [3:0] r, input logic [11:0] d, input logic h,
                       input logic [3:0] f, input logic rs);
        req_vld  = r;
        req_data = d;
        wr_hold  = h;
        fwd_thr  = f;
        reset    = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(); cyc(4'b0, 12'h0, 1'b0, 4'b0, 1'b0); endtask
    task automatic do_reset(); cyc(4'b0, 12'h0, 1'b0, 4'b0, 1'b1); endtask

    initial begin
        logic [3:0] fsel;
        do_reset();
        do_reset();
        chk("rst_wen", 16'(wen_w), 16'h0);
        chk("rst_pend", 16'(pend), 16'h0);
        chk("rst_fwd", 16'(fwd_vld), 16'h0);

        // Two threads, two consecutive writes.
        cyc(4'b0101, {3'h0, 3'h2, 3'h0, 3'h5}, 1'b0, 4'b0, 1'b0);
        chk("t1_pend", 16'(pend), 16'h5);
        chk("t1_wen_pre", 16'(wen_w), 16'h0);
        idle();
        chk("t1_thr0", 16'(thr_w), 16'h1);
        chk("t1_dat0", 16'(data_in_w), 16'h5);
        idle();
        chk("t1_thr2", 16'(thr_w), 16'h4);
        chk("t1_dat2", 16'(data_in_w), 16'h2);
        idle();
        chk("t1_pend_end", 16'(pend), 16'h0);
        chk("t1_wen_end", 16'(wen_w), 16'h0);

        // Four-way burst from reset drains in thread order, then wraps to thread 0.
        do_reset();
        cyc(4'b1111, {3'h4, 3'h3, 3'h2, 3'h1}, 1'b0, 4'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t2_thr", 16'(thr_w), 16'(1 << i));
            chk("t2_dat", 16'(data_in_w), 16'(i + 1));
        end
        cyc(4'b0011, {3'h0, 3'h0, 3'h6, 3'h7}, 1'b0, 4'b0, 1'b0);
        idle();
        chk("t2_wrap_thr", 16'(thr_w), 16'h1);
        chk("t2_wrap_dat", 16'(data_in_w), 16'h7);
        idle();
        chk("t2_next_thr", 16'(thr_w), 16'h2);
        idle();

        // Request arriving in the grant cycle stays pending.
        cyc(4'b0010, {3'h0, 3'h0, 3'h1, 3'h0}, 1'b0, 4'b0, 1'b0);
        cyc(4'b0010, {3'h0, 3'h0, 3'h6, 3'h0}, 1'b0, 4'b0, 1'b0);
        chk("t3_dat_old", 16'(data_in_w), 16'h1);
        chk("t3_pend1", 16'(pend), 16'h2);
        idle();
        chk("t3_dat_new", 16'(data_in_w), 16'h6);
        chk("t3_pend0", 16'(pend), 16'h0);
        idle();

        // Hold: no writes, last request wins after release.
        cyc(4'b1000, {3'h7, 9'h0}, 1'b1, 4'b0, 1'b0);
        chk("t4_hold_a", 16'(wen_w), 16'h0);
        cyc(4'b1000, {3'h4, 9'h0}, 1'b1, 4'b0, 1'b0);
        chk("t4_hold_b", 16'(wen_w), 16'h0);
        cyc(4'b0000, 12'h0, 1'b1, 4'b0, 1'b0);
        chk("t4_hold_c", 16'(wen_w), 16'h0);
        idle();
        chk("t4_thr3", 16'(thr_w), 16'h8);
        chk("t4_dat4", 16'(data_in_w), 16'h4);
        idle();
        chk("t4_single", 16'(wen_w), 16'h0);

        // Forwarding of thread 1 while pending and while issuing.
        cyc(4'b0010, {3'h0, 3'h0, 3'h3, 3'h0}, 1'b0, 4'b0010, 1'b0);
`ifdef SPARC_EXU_REG_WRCTL_FWD_EN
        chk("t5_fvld_pend", 16'(fwd_vld), 16'h1);
        chk("t5_fdat_pend", 16'(fwd_data), 16'h3);
        cyc(4'b0, 12'h0, 1'b0, 4'b0010, 1'b0);
        chk("t5_fvld_iss", 16'(fwd_vld), 16'h1);
        chk("t5_fdat_iss", 16'(fwd_data), 16'h3);
`else
        chk("t5_fvld_off", 16'(fwd_vld), 16'h0);
        cyc(4'b0, 12'h0, 1'b0, 4'b0010, 1'b0);
        chk("t5_fvld_off2", 16'(fwd_vld), 16'h0);
`endif
        cyc(4'b0, 12'h0, 1'b0, 4'b0010, 1'b0);
        chk("t5_fvld_done", 16'(fwd_vld), 16'h0);

        // Reset with all threads pending discards everything.
        cyc(4'b1111, 12'hfff, 1'b0, 4'b0, 1'b0);
        chk("t6_pend_all", 16'(pend), 16'hf);
        do_reset();
        chk("t6_wen", 16'(wen_w), 16'h0);
        chk("t6_pend", 16'(pend), 16'h0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t6_quiet", 16'(wen_w), 16'h0);
        end

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: fsel = 4'b0000;
                1: fsel = 4'b0001;
                2: fsel = 4'b0010;
                3: fsel = 4'b0100;
                default: fsel = 4'b1000;
            endcase
            cyc(4'($urandom_range(0, 15) & $urandom_range(0, 15)), 12'($urandom),
                ($urandom_range(0, 3) == 0), fsel, ($urandom_range(0, 63) == 0));
        end
        idle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
